// File: rtl/alu_seq_param.sv
// Registered ALU with iterative one-bit-per-cycle shifter and a start/busy/done handshake.
// Optional build macro ALU_SAT_EN: ADD/SUB saturate on signed overflow instead of wrapping.
`timescale 1ns/1ps

module alu_seq_param #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SLL = 3'b011,
        OP_SRL = 3'b100,
        OP_SRA = 3'b101,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    op_t                op_in;
    op_t                sh_op;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;

    assign op_in    = op_t'(op);
    assign shamt    = b[SHAMT_W-1:0];
    assign is_shift = (op_in == OP_SLL) || (op_in == OP_SRL) || (op_in == OP_SRA);

    // SUB and SLT share the adder as a + ~b + 1.
    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             add_ovf;
    logic             slt_bit;

    assign sub_mode = (op_in == OP_SUB) || (op_in == OP_SLT);
    assign b_eff    = sub_mode ? ~b : b;
    assign sum_full = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
    assign sum      = sum_full[WIDTH-1:0];
    assign carry    = sum_full[WIDTH];
    assign add_ovf  = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
    assign slt_bit  = sum[MSB] ^ add_ovf;

    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_ov;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        res    = '0;
        res_c  = 1'b0;
        res_ov = 1'b0;
        case (op_in)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_ADD, OP_SUB: begin
                res    = sum;
                res_c  = carry;
                res_ov = add_ovf;
`ifdef ALU_SAT_EN
                // Overflow direction follows the sign of a for both ADD and SUB.
                if (add_ovf)
                    res = a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}}, slt_bit};
            // Only a zero-amount shift completes from IDLE; it passes a through.
            default: res = a;
        endcase
    end

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = work;
        case (sh_op)
            OP_SLL:  shifted = {work[MSB-1:0], 1'b0};
            OP_SRL:  shifted = {1'b0, work[MSB:1]};
            default: shifted = {work[MSB], work[MSB:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state    <= IDLE;
            sh_op    <= OP_SLL;
            work     <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            r        <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_shift && (shamt != '0)) begin
                            work  <= a;
                            sh_op <= op_in;
                            cnt   <= shamt;
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end else begin
                            r        <= res;
                            c_out    <= res_c;
                            overflow <= res_ov;
                            zero     <= (res == '0);
                            done     <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        r        <= shifted;
                        c_out    <= 1'b0;
                        overflow <= 1'b0;
                        zero     <= (shifted == '0);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param: directed vectors, random ops against an
// arithmetic reference model, back-to-back issue, start-while-busy and reset abort.
`timescale 1ns/1ps

module tb_alu_seq_param;

    localparam int W  = 16;
    localparam int SH = 4;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'b000;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, c_out, overflow, zero;
    logic [W-1:0] r;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq_param #(.WIDTH(W), .SHAMT_W(SH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .r        (r),
        .c_out    (c_out),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         ov;
        logic         z;
    } res_t;

    typedef struct {
        logic [2:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic         c;
        logic         ov;
        logic         z;
    } vec_t;

    // Reference model: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t                e;
        longint              ux, uy, sx, sy, t, smax, smin;
        int                  s;
        logic signed [W-1:0] xs;
        e    = '0;
        ux   = longint'(x);
        uy   = longint'(y);
        sx   = $signed(x);
        sy   = $signed(y);
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        s    = int'(y[SH-1:0]);
        t    = 0;
        xs   = x;
        case (o)
            3'b000: e.r = x & y;
            3'b001: e.r = x | y;
            3'b010: begin
                e.r  = W'(ux + uy);
                e.c  = (ux + uy) >= (longint'(1) << W);
                t    = sx + sy;
                e.ov = (t > smax) || (t < smin);
            end
            3'b110: begin
                e.r  = W'(ux - uy);
                e.c  = (ux >= uy);
                t    = sx - sy;
                e.ov = (t > smax) || (t < smin);
            end
            3'b111: e.r = (sx < sy) ? W'(1) : '0;
            3'b011: e.r = x << s;
            3'b100: e.r = x >> s;
            default: e.r = xs >>> s;
        endcase
`ifdef ALU_SAT_EN
        if (e.ov) e.r = (t > smax) ? W'(smax) : W'(smin);
`endif
        e.z = (e.r == '0);
        return e;
    endfunction

    function automatic int busy_len(input logic [2:0] o, input logic [W-1:0] y);
        if (o == 3'b011 || o == 3'b100 || o == 3'b101) return int'(y[SH-1:0]);
        return 0;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, r, c_out, overflow, zero} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b done=%b r=%h c=%b ov=%b z=%b, want all 0",
                     busy, done, r, c_out, overflow, zero);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_directed();
        vec_t tab[14];
        logic [W-1:0] r_ovf_add, r_ovf_sub;
`ifdef ALU_SAT_EN
        r_ovf_add = 16'h7FFF;
        r_ovf_sub = 16'h8000;
`else
        r_ovf_add = 16'hEA60;
        r_ovf_sub = 16'h15A0;
`endif
        tab[0]  = '{3'b010, 16'd20000, 16'd14,    16'd20014, 1'b0, 1'b0, 1'b0};
        tab[1]  = '{3'b010, 16'd30000, 16'd30000, r_ovf_add, 1'b0, 1'b1, 1'b0};
        tab[2]  = '{3'b110, 16'h8AD0,  16'd30000, r_ovf_sub, 1'b1, 1'b1, 1'b0};
        tab[3]  = '{3'b110, 16'd8,     16'd4,     16'd4,     1'b1, 1'b0, 1'b0};
        tab[4]  = '{3'b110, 16'd5,     16'd5,     16'd0,     1'b1, 1'b0, 1'b1};
        tab[5]  = '{3'b111, 16'hFFFD,  16'd2,     16'd1,     1'b0, 1'b0, 1'b0};
        tab[6]  = '{3'b111, 16'd2,     16'hFFFD,  16'd0,     1'b0, 1'b0, 1'b1};
        tab[7]  = '{3'b101, 16'h8000,  16'd4,     16'hF800,  1'b0, 1'b0, 1'b0};
        tab[8]  = '{3'b011, 16'h1234,  16'd0,     16'h1234,  1'b0, 1'b0, 1'b0};
        tab[9]  = '{3'b000, 16'hFFFF,  16'h0000,  16'h0000,  1'b0, 1'b0, 1'b1};
        tab[10] = '{3'b001, 16'hAAAA,  16'h5555,  16'hFFFF,  1'b0, 1'b0, 1'b0};
        tab[11] = '{3'b100, 16'hF0F0,  16'h0013,  16'h1E1E,  1'b0, 1'b0, 1'b0};
        tab[12] = '{3'b011, 16'h0001,  16'd15,    16'h8000,  1'b0, 1'b0, 1'b0};
        tab[13] = '{3'b010, 16'hFFFF,  16'h0001,  16'h0000,  1'b1, 1'b0, 1'b1};
        foreach (tab[i]) begin
            int n;
            op    = tab[i].o;
            a     = tab[i].x;
            b     = tab[i].y;
            n     = busy_len(tab[i].o, tab[i].y);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < n; k++) begin
                n_cmp++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL dir%0d_busy_cycle%0d: got busy=%b done=%b, want 1 0", i, k + 1, busy, done);
                end
                // A start pulse while busy must be dropped.
                start = 1'b1;
                op    = 3'b010;
                a     = W'($urandom);
                b     = W'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
            n_cmp++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL dir%0d_done: got done=%b busy=%b, want 1 0", i, done, busy);
            end
            n_cmp++;
            if ({r, c_out, overflow, zero} !== {tab[i].r, tab[i].c, tab[i].ov, tab[i].z}) begin
                n_bad++;
                $display("FAIL dir%0d_result: got r=%h c=%b ov=%b z=%b, want r=%h c=%b ov=%b z=%b",
                         i, r, c_out, overflow, zero, tab[i].r, tab[i].c, tab[i].ov, tab[i].z);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || r !== tab[i].r) begin
                n_bad++;
                $display("FAIL dir%0d_hold: got done=%b busy=%b r=%h, want 0 0 %h", i, done, busy, r, tab[i].r);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops [5];
        logic [W-1:0] xs  [5];
        logic [W-1:0] ys  [5];
        logic [2:0]   pick [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
        res_t e;
        for (int i = 0; i < 5; i++) begin
            ops[i] = pick[$urandom_range(0, 4)];
            xs[i]  = W'($urandom);
            ys[i]  = W'($urandom);
        end
        op    = ops[0];
        a     = xs[0];
        b     = ys[0];
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            e = model(ops[i], xs[i], ys[i]);
            n_cmp++;
            if (done !== 1'b1 || {r, c_out, overflow, zero} !== e) begin
                n_bad++;
                $display("FAIL b2b%0d: got done=%b r=%h c=%b ov=%b z=%b, want done=1 r=%h c=%b ov=%b z=%b",
                         i, done, r, c_out, overflow, zero, e.r, e.c, e.ov, e.z);
            end
            if (i < 4) begin
                op = ops[i+1];
                a  = xs[i+1];
                b  = ys[i+1];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: got done=%b, want 0", done);
        end
    endtask

    task automatic test_random(input int count);
        res_t         e;
        logic [W-1:0] prev_r;
        prev_r = r;
        for (int i = 0; i < count; i++) begin
            int n;
            op    = 3'($urandom);
            a     = W'($urandom);
            b     = W'($urandom);
            if ($urandom_range(0, 3) == 0) b[SH-1:0] = '0;
            e     = model(op, a, b);
            n     = busy_len(op, b);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < n; k++) begin
                n_cmp++;
                if (busy !== 1'b1 || done !== 1'b0 || r !== prev_r) begin
                    n_bad++;
                    $display("FAIL rnd%0d_busy_cycle%0d: got busy=%b done=%b r=%h, want 1 0 %h",
                             i, k + 1, busy, done, r, prev_r);
                end
                start = 1'($urandom);
                op    = 3'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
            n_cmp++;
            if (done !== 1'b1 || busy !== 1'b0 || {r, c_out, overflow, zero} !== e) begin
                n_bad++;
                $display("FAIL rnd%0d_result: got done=%b busy=%b r=%h c=%b ov=%b z=%b, want 1 0 r=%h c=%b ov=%b z=%b",
                         i, done, busy, r, c_out, overflow, zero, e.r, e.c, e.ov, e.z);
            end
            prev_r = e.r;
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || {r, c_out, overflow, zero} !== e) begin
                n_bad++;
                $display("FAIL rnd%0d_hold: got done=%b r=%h, want 0 %h", i, done, r, e.r);
            end
        end
    endtask

    task automatic test_reset_abort();
        op    = 3'b001;
        a     = 16'hAAAA;
        b     = 16'h5555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (r !== 16'hFFFF || done !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_setup: got r=%h done=%b, want ffff 1", r, done);
        end
        op    = 3'b100;
        a     = 16'hFFFF;
        b     = 16'd15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_busy_cycle%0d: got busy=%b done=%b, want 1 0", k, busy, done);
            end
            if (k < 7) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({busy, done, r, c_out, overflow, zero} !== '0) begin
            n_bad++;
            $display("FAIL abort_reset_state: got busy=%b done=%b r=%h c=%b ov=%b z=%b, want all 0",
                     busy, done, r, c_out, overflow, zero);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_no_done%0d: got done=%b busy=%b, want 0 0", k, done, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random(150);
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
